// File: rtl/cmos_capture_ctrl.sv
// Frame-capture controller: arms on start, aligns to a frame boundary, skips N frames, forwards M frames.
// Outputs are registered (1 clk latency); geometry check flags pixels-per-line and lines-per-frame mismatches.
module cmos_capture_ctrl #(
  parameter bit          VSYNC_VALID_HIGH = 1'b1,
  parameter logic [10:0] IMG_HDISP        = 11'd640,
  parameter logic [10:0] IMG_VDISP        = 11'd480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [3:0]  cfg_skip,
  input  logic [7:0]  cfg_frames,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        out_vsync,
  output logic        out_href,
  output logic [7:0]  out_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt,
  output logic [10:0] line_cnt_last,
  output logic        err_flag
);

  typedef enum logic [2:0] {IDLE, WAIT_SYNC, SKIP, CAPTURE, DONE} state_t;

  state_t      state, state_nxt;
  logic        vs_act, vs_d, href_d, rise, fall, href_fall, cap_en;
  logic [3:0]  skip_cnt, skip_cnt_nxt;
  logic [7:0]  frames_lat, frames_lat_nxt, frame_cnt_nxt;
  logic        done_nxt, stop_pending, stop_pending_nxt;
  logic        frame_start_nxt, frame_end, clr_err, geo_err;
  logic [10:0] pix, lines;

  assign vs_act    = VSYNC_VALID_HIGH ? cmos_vsync : ~cmos_vsync;
  assign rise      = vs_act & ~vs_d;
  assign fall      = ~vs_act & vs_d;
  assign href_fall = ~cmos_href & href_d;
  assign cap_en    = (state == CAPTURE) | ((state == WAIT_SYNC) & rise & (skip_cnt == 4'd0));
  assign busy      = (state == WAIT_SYNC) | (state == SKIP) | (state == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      skip_cnt     <= '0;
      frames_lat   <= '0;
      frame_cnt    <= '0;
      done         <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      skip_cnt     <= skip_cnt_nxt;
      frames_lat   <= frames_lat_nxt;
      frame_cnt    <= frame_cnt_nxt;
      done         <= done_nxt;
      stop_pending <= stop_pending_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    skip_cnt_nxt     = skip_cnt;
    frames_lat_nxt   = frames_lat;
    frame_cnt_nxt    = frame_cnt;
    done_nxt         = done;
    stop_pending_nxt = stop_pending;
    frame_start_nxt  = 1'b0;
    frame_end        = 1'b0;
    clr_err          = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cfg_start) begin
          skip_cnt_nxt     = cfg_skip;
          frames_lat_nxt   = cfg_frames;
          frame_cnt_nxt    = '0;
          done_nxt         = 1'b0;
          stop_pending_nxt = 1'b0;
          clr_err          = 1'b1;
          state_nxt        = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (cfg_stop) begin
          state_nxt = IDLE;
        end else if (rise) begin
          if (skip_cnt != 4'd0) begin
            state_nxt = SKIP;
          end else begin
            state_nxt       = CAPTURE;
            frame_start_nxt = 1'b1;
          end
        end
      end
      SKIP: begin
        if (cfg_stop) begin
          state_nxt = IDLE;
        end else if (fall) begin
          skip_cnt_nxt = skip_cnt - 4'd1;
          state_nxt    = WAIT_SYNC;
        end
      end
      CAPTURE: begin
        if (cfg_stop) stop_pending_nxt = 1'b1;
        if (fall) begin
          frame_end     = 1'b1;
          frame_cnt_nxt = frame_cnt + 8'd1;
          // A pending stop ends in IDLE even if the count was also reached.
          if (stop_pending | cfg_stop) begin
            state_nxt        = IDLE;
            stop_pending_nxt = 1'b0;
          end else if ((frames_lat != 8'd0) && (frame_cnt_nxt == frames_lat)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_SYNC;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign geo_err = (cap_en & href_fall & (pix != IMG_HDISP)) | (frame_end & (lines != IMG_VDISP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d          <= 1'b0;
      href_d        <= 1'b0;
      pix           <= '0;
      lines         <= '0;
      out_vsync     <= 1'b0;
      out_href      <= 1'b0;
      out_data      <= '0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      line_cnt_last <= '0;
      err_flag      <= 1'b0;
    end else begin
      vs_d        <= vs_act;
      href_d      <= cmos_href;
      out_vsync   <= cap_en & vs_act;
      out_href    <= cap_en & cmos_href;
      out_data    <= (cap_en & cmos_href) ? cmos_data : 8'd0;
      frame_start <= frame_start_nxt;
      frame_done  <= frame_end;
      if (frame_end) line_cnt_last <= lines;
      if (clr_err) err_flag <= 1'b0;
      else if (geo_err) err_flag <= 1'b1;
      if (rise) begin
        pix   <= '0;
        lines <= '0;
      end else if (cap_en) begin
        if (href_fall) begin
          pix <= '0;
          if (lines != 11'h7FF) lines <= lines + 11'd1;
        end else if (cmos_href && (pix != 11'h7FF)) begin
          pix <= pix + 11'd1;
        end
      end
    end
  end

endmodule
